uart_tx: RTL
============

# uart_tx

UART transmitter: serializes one parallel byte per request into a start/data/optional-parity/stop frame on `tx_out`. It pairs with the receive path and shares its `prescale` timing convention: `prescale` is clock cycles per bit, so both ends run from the same oversampling clock. It sits between the host-side byte producer and the serial pin.

## Interface
- `DATA_WIDTH`, default 8: data bits per frame.
- `clk`, in, 1: single clock; all logic is on its rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `p_data`, in, DATA_WIDTH: byte to send; sampled on acceptance.
- `data_valid`, in, 1: transmit request; honoured only in IDLE.
- `par_en`, in, 1: 1 inserts a parity bit; sampled on acceptance.
- `par_typ`, in, 1: 0 = even parity, 1 = odd parity; sampled on acceptance.
- `prescale`, in, 6: clock cycles per bit (P); sampled on acceptance.
- `tx_out`, out, 1: serial line, registered, idles high.
- `busy`, out, 1: high while a frame is in progress.
- `tx_done`, out, 1: one-cycle pulse when the last stop-bit cycle ends.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Reset: state IDLE, `tx_out`=1, `busy`=0, `tx_done`=0, and all counters and shadow registers cleared.
- IDLE with `data_valid`=1 accepts the request. It latches `p_data`, `par_en`, `par_typ` and P, then enters START.
- Latched P of 0 is treated as 1. Legal range is 1..63.
- Each bit is held for exactly P cycles.
  - An edge counter counts 0..P-1.
  - A bit counter advances when the edge counter reaches P-1.
- START: `tx_out`=0 for P cycles, then DATA.
- DATA: bits are sent LSB first, `p_data[0]` through `p_data[DATA_WIDTH-1]`. After the last bit, go to PARITY if `par_en`=1, else STOP.
- PARITY: `tx_out` = XOR-reduce(latched data) XOR `par_typ`, held for P cycles.
- STOP: `tx_out`=1 for P cycles. Then return to IDLE, drop `busy`, and pulse `tx_done`.
- `data_valid` is ignored in every state other than IDLE. Requests made while `busy`=1 are dropped, not queued.
- Changes to `p_data`, `par_en`, `par_typ` or `prescale` after acceptance have no effect on the current frame.
- `rst` asserted mid-frame abandons the frame. On the next edge: `tx_out`=1, `busy`=0, `tx_done`=0, state IDLE. No partial stop bit is sent.
- If `rst` and `data_valid` are high on the same edge, reset wins and the request is dropped.

## Timing
- Let the acceptance edge be k (IDLE, `data_valid`=1).
- From edge k+1, `tx_out`=0 and `busy`=1. The start bit occupies cycles k+1..k+P.
- Data bit i occupies cycles k+1+P(1+i) .. k+P(2+i).
- Parity bit, if enabled, occupies the P cycles after data bit DATA_WIDTH-1.
- Stop bit: the next P cycles.
- `busy` is high for exactly P·(DATA_WIDTH+2) cycles without parity, or P·(DATA_WIDTH+3) cycles with parity.
- `tx_done` is high for one cycle: the first IDLE cycle after STOP. `busy` is 0 in that same cycle.
- Back-to-back sends: the earliest new acceptance is the first IDLE cycle, i.e. the cycle where `tx_done`=1. This gives exactly one extra idle-high cycle between frames.
- Latency: acceptance edge to start-bit leading edge is 1 cycle.

## Test plan
- Reset, then `p_data`=0xA5, P=4, `par_en`=0, one-cycle `data_valid`.
  - `tx_out` shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles.
  - `busy` is high for 40 cycles, then `tx_done` pulses once.
- 0xA5, P=4, `par_en`=1, `par_typ`=0 gives parity bit 0. Repeat with `par_typ`=1: parity bit 1. Both frames have `busy` high for 44 cycles.
- 0x01, P=1, odd parity: 11-cycle frame 0,1,0,0,0,0,0,0,0,0,1 (parity bit 0). Repeat with P=0 and check the identical waveform.
- `data_valid` held high continuously with `p_data` changing mid-frame.
  - Each frame carries the byte present on its acceptance cycle.
  - Exactly one idle-high cycle separates frames.
  - No request is accepted while `busy`=1.
- Assert `rst` for one cycle during data bit 3 of a P=8 frame. On the next edge: `tx_out`=1, `busy`=0, no `tx_done`. A new request afterwards transmits a complete, correct frame.
- Hold `rst` and `data_valid` together for one cycle. No frame starts and `tx_out` stays 1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Accepts one parallel word per request while idle.
// Sends it as a start bit, DATA_WIDTH data bits (LSB first), an optional parity
// bit and a stop bit. Every bit is held for `prescale` clock cycles.
//
// Ports:
//   clk        - clock, all logic on rising edge
//   rst        - synchronous active-high reset
//   p_data     - word to send, sampled on acceptance
//   data_valid - transmit request, honoured only when idle
//   par_en     - 1 inserts a parity bit, sampled on acceptance
//   par_typ    - 0 even / 1 odd parity, sampled on acceptance
//   prescale   - clock cycles per bit (0 treated as 1), sampled on acceptance
//   tx_out     - registered serial line, idles high
//   busy       - high while a frame is in progress
//   tx_done    - one-cycle pulse in the first idle cycle after the stop bit
module uart_tx #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [5:0]            prescale,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned PW = 6;
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                  state, state_n;
    logic [PW-1:0]           edge_cnt, edge_n;
    logic [BW-1:0]           bit_cnt, bit_n;
    logic [DATA_WIDTH-1:0]   shift_q, shift_n;
    logic                    par_en_q, par_en_n;
    logic                    par_bit_q, par_bit_n;
    logic [PW-1:0]           pm1_q, pm1_n;
    logic                    tx_n, busy_n, done_n;
    logic                    bit_end;

    // State, counters, shadow registers and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            pm1_q     <= '0;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_n;
            edge_cnt  <= edge_n;
            bit_cnt   <= bit_n;
            shift_q   <= shift_n;
            par_en_q  <= par_en_n;
            par_bit_q <= par_bit_n;
            pm1_q     <= pm1_n;
            tx_out    <= tx_n;
            busy      <= busy_n;
            tx_done   <= done_n;
        end
    end

    // Next-state and next-output logic; tx_n is the line level for the next cycle
    always_comb begin
        state_n   = state;
        edge_n    = edge_cnt;
        bit_n     = bit_cnt;
        shift_n   = shift_q;
        par_en_n  = par_en_q;
        par_bit_n = par_bit_q;
        pm1_n     = pm1_q;
        tx_n      = tx_out;
        busy_n    = busy;
        done_n    = 1'b0;
        bit_end   = (edge_cnt == pm1_q);

        if (state != S_IDLE) begin
            edge_n = bit_end ? '0 : edge_cnt + PW'(1);
        end

        case (state)
            S_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (data_valid) begin
                    state_n   = S_START;
                    shift_n   = p_data;
                    par_en_n  = par_en;
                    // Parity precomputed here since the shift register is consumed
                    par_bit_n = (^p_data) ^ par_typ;
                    pm1_n     = (prescale == '0) ? '0 : prescale - PW'(1);
                    edge_n    = '0;
                    bit_n     = '0;
                    tx_n      = 1'b0;
                    busy_n    = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_n = S_DATA;
                    tx_n    = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_n = S_PARITY;
                            tx_n    = par_bit_q;
                        end else begin
                            state_n = S_STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n   = bit_cnt + BW'(1);
                        shift_n = shift_q >> 1;
                        tx_n    = shift_n[0];
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_n = S_STOP;
                    tx_n    = 1'b1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_n = S_IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule
